// File: rtl/sfu_bank.sv
// sfu_bank: multi-column special-function bank.
// Accumulates col signed psum lanes into a depth-entry buffer over a
// programmable number of passes, then drains with optional ReLU and signed
// saturation over valid/ready.
// Optional feature macro: SFU_BANK_REQUANT_EN adds cfg_shift and a
// round-half-up arithmetic right shift ahead of ReLU/saturation.
module sfu_bank #(
    parameter int unsigned col     = 8,
    parameter int unsigned psum_bw = 16,
    parameter int unsigned acc_bw  = 20,
    parameter int unsigned depth   = 16,
    parameter int unsigned addr_bw = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [addr_bw-1:0]       cfg_len_m1,
    input  logic [7:0]               cfg_passes_m1,
    input  logic                     cfg_relu,
`ifdef SFU_BANK_REQUANT_EN
    input  logic [3:0]               cfg_shift,
`endif
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [psum_bw*col-1:0]   in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [psum_bw*col-1:0]   out_data,
    output logic [addr_bw-1:0]       out_addr,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned data_bw = psum_bw * col;
    localparam int unsigned ext_bw  = acc_bw + 1;
    localparam logic signed [ext_bw-1:0] sat_max = ext_bw'((1 << (psum_bw - 1)) - 1);
    localparam logic signed [ext_bw-1:0] sat_min = ext_bw'(-(1 << (psum_bw - 1)));

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [addr_bw-1:0] wr_ptr;
    logic [addr_bw-1:0] rd_ptr;
    logic [7:0]         pass;
    logic [addr_bw-1:0] len_q;
    logic [7:0]         passes_q;
    logic               relu_q;
`ifdef SFU_BANK_REQUANT_EN
    logic [3:0]         shift_q;
`endif

    logic accept;
    logic last_in;
    logic hs;
    logic last_out;
    logic load;

    logic [addr_bw-1:0]        drain_idx;
    logic [data_bw-1:0]        out_data_d;
    logic signed [acc_bw-1:0]  acc_new [col];
    logic signed [acc_bw-1:0]  acc [depth][col];

    // Sign-extend one psum lane to accumulator width.
    function automatic logic signed [acc_bw-1:0] sext(input logic [psum_bw-1:0] v);
        logic signed [psum_bw-1:0] s;
        s = $signed(v);
        return acc_bw'(s);
    endfunction

    // Drain post-processing: optional requant shift, ReLU, then signed saturation.
    function automatic logic [psum_bw-1:0] post(
        input logic signed [acc_bw-1:0] a,
        input logic                     relu
`ifdef SFU_BANK_REQUANT_EN
        ,
        input logic [3:0]               sh
`endif
    );
        logic signed [ext_bw-1:0] w;
        w = ext_bw'(a);
`ifdef SFU_BANK_REQUANT_EN
        if (sh != 4'd0) begin
            w = w + (ext_bw'(1) <<< (sh - 4'd1));
        end
        w = w >>> sh;
`endif
        if (relu && w[ext_bw-1]) begin
            w = '0;
        end
        if (w > sat_max) begin
            return psum_bw'(sat_max);
        end else if (w < sat_min) begin
            return psum_bw'(sat_min);
        end
        return psum_bw'(w);
    endfunction

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and handshake qualifiers.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last_in    = 1'b0;
        hs         = 1'b0;
        last_out   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = ACC;
                end
            end
            ACC: begin
                accept = in_valid && in_ready;
                if (accept && (wr_ptr == len_q) && (pass == passes_q)) begin
                    last_in    = 1'b1;
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                hs = out_valid && out_ready;
                if (hs && (rd_ptr == len_q)) begin
                    last_out   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // New accumulator value per lane: first pass overwrites, later passes add.
    always_comb begin
        for (int i = 0; i < int'(col); i++) begin
            acc_new[i] = sext(in[i*psum_bw +: psum_bw]);
            if (pass != 8'd0) begin
                acc_new[i] = acc[wr_ptr][i] + sext(in[i*psum_bw +: psum_bw]);
            end
        end
    end

    // Next drained word; bypasses the in-flight write when entering DRAIN on entry 0.
    always_comb begin
        load       = last_in || (hs && !last_out);
        drain_idx  = last_in ? '0 : (rd_ptr + 1'b1);
        out_data_d = '0;
        for (int i = 0; i < int'(col); i++) begin
            out_data_d[i*psum_bw +: psum_bw] = post(
                (accept && (wr_ptr == drain_idx)) ? acc_new[i] : acc[drain_idx][i],
                relu_q
`ifdef SFU_BANK_REQUANT_EN
                ,
                shift_q
`endif
            );
        end
    end

    // Accumulator storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < int'(col); i++) begin
                acc[wr_ptr][i] <= acc_new[i];
            end
        end
    end

    // Configuration latches, pointers and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            pass      <= '0;
            len_q     <= '0;
            passes_q  <= '0;
            relu_q    <= 1'b0;
`ifdef SFU_BANK_REQUANT_EN
            shift_q   <= '0;
`endif
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
        end else begin
            in_ready  <= (state_next == ACC);
            out_valid <= (state_next == DRAIN);
            busy      <= (state_next != IDLE);
            done      <= last_out;

            if ((state == IDLE) && start) begin
                len_q    <= cfg_len_m1;
                passes_q <= cfg_passes_m1;
                relu_q   <= cfg_relu;
`ifdef SFU_BANK_REQUANT_EN
                shift_q  <= cfg_shift;
`endif
                wr_ptr   <= '0;
                pass     <= '0;
            end

            if (accept) begin
                if (wr_ptr == len_q) begin
                    wr_ptr <= '0;
                    pass   <= pass + 8'd1;
                end else begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
            end

            if (last_in) begin
                rd_ptr <= '0;
            end else if (hs) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            if (load) begin
                out_data <= out_data_d;
                out_addr <= drain_idx;
            end
        end
    end

endmodule
